neureka_tcdm_splitter: RTL and testbench

- Splits one wide HCI-style TCDM master request into MP independent 32-bit TCDM ports.
- Sits between the Neureka streamer and the cluster interconnect.
- Unlike a plain lock-step binding, it accepts grants per port on different cycles and does not drive write ports whose byte-enable slice is zero.
- It buffers per-port read responses and reassembles them into one wide response with back-pressure, bounded by an outstanding-read credit counter.

---
 rtl/neureka_tcdm_splitter_pkg.sv | 13 +
 rtl/neureka_tcdm_splitter_resp_fifo.sv | 57 +++++
 rtl/neureka_tcdm_splitter.sv | 116 +++++++++++
 tb/tb_neureka_tcdm_splitter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neureka_tcdm_splitter_pkg.sv
// Shared constants and helpers for the Neureka wide-to-narrow TCDM splitter.
package neureka_tcdm_splitter_pkg;

    localparam int unsigned NEUREKA_SPLIT_MP     = 9;
    localparam int unsigned NEUREKA_SPLIT_RDEPTH = 4;
    localparam int unsigned NEUREKA_PORT_DW      = 32;

    // Narrow ports are word-interleaved starting at the wide base address.
    function automatic logic [31:0] port_addr(input logic [31:0] base, input int unsigned idx);
        return base + 32'(idx * 4);
    endfunction

endpackage

// File: rtl/neureka_tcdm_splitter_resp_fifo.sv
// First-word-fall-through 32-bit response FIFO for one narrow TCDM port.
module neureka_tcdm_resp_fifo
    import neureka_tcdm_splitter_pkg::*;
#(
    parameter int unsigned DEPTH = NEUREKA_SPLIT_RDEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [NEUREKA_PORT_DW-1:0] i_data,
    input  logic                       i_pop,
    output logic [NEUREKA_PORT_DW-1:0] o_data,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [NEUREKA_PORT_DW-1:0] r_mem [DEPTH];
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CW-1:0]              r_cnt;
    logic                       w_push;
    logic                       w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(i_push && o_full));

endmodule

// File: rtl/neureka_tcdm_splitter.sv
// Splits one wide TCDM request into MP narrow ports with per-port grant accumulation,
// and reassembles per-port read responses under an outstanding-read credit limit.
module neureka_tcdm_splitter
    import neureka_tcdm_splitter_pkg::*;
#(
    parameter int unsigned MP      = NEUREKA_SPLIT_MP,
    parameter int unsigned BW      = MP * 32,
    parameter int unsigned R_DEPTH = NEUREKA_SPLIT_RDEPTH,
    parameter bit          GATE_BE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [31:0]      add_i,
    input  logic             wen_i,
    input  logic [BW/8-1:0]  be_i,
    input  logic [BW-1:0]    data_i,
    output logic [BW-1:0]    r_data_o,
    output logic             r_valid_o,
    input  logic             r_ready_i,
    output logic [MP-1:0]    tcdm_req_o,
    input  logic [MP-1:0]    tcdm_gnt_i,
    output logic [MP*32-1:0] tcdm_add_o,
    output logic [MP-1:0]    tcdm_wen_o,
    output logic [MP*4-1:0]  tcdm_be_o,
    output logic [MP*32-1:0] tcdm_data_o,
    input  logic [MP*32-1:0] tcdm_r_data_i,
    input  logic [MP-1:0]    tcdm_r_valid_i
);

    localparam int unsigned CW = $clog2(R_DEPTH + 1);

    logic [MP-1:0] r_granted;
    logic [MP-1:0] w_granted_d;
    logic [MP-1:0] w_need;
    logic [MP-1:0] w_hs;
    logic [MP-1:0] w_empty;
    logic [MP-1:0] w_full;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] w_outst_d;
    logic          w_credit_ok;
    logic          w_pop;
    logic          w_inc;

    always_comb begin
        w_need = '0;
        for (int i = 0; i < MP; i++) begin
            w_need[i] = wen_i | ~GATE_BE | (|be_i[4*i +: 4]);
        end
    end

    assign w_credit_ok = ~wen_i | (r_outst < CW'(R_DEPTH));
    assign tcdm_req_o  = {MP{req_i & w_credit_ok}} & w_need & ~r_granted;
    assign w_hs        = tcdm_req_o & tcdm_gnt_i;
    // Ports already granted, granted now, or not needed all count as done.
    assign gnt_o       = req_i & w_credit_ok & (&(r_granted | w_hs | ~w_need));

    always_comb begin
        tcdm_add_o = '0;
        for (int i = 0; i < MP; i++) begin
            tcdm_add_o[32*i +: 32] = port_addr(add_i, i);
        end
    end

    assign tcdm_wen_o  = {MP{wen_i}};
    assign tcdm_be_o   = be_i;
    assign tcdm_data_o = data_i;

    assign w_granted_d = gnt_o ? '0 : (r_granted | w_hs);

    assign r_valid_o = ~(|w_empty);
    assign w_pop     = r_valid_o & r_ready_i;
    assign w_inc     = gnt_o & wen_i;

    always_comb begin
        w_outst_d = r_outst;
        unique case ({w_inc, w_pop})
            2'b10:   w_outst_d = r_outst + CW'(1);
            2'b01:   w_outst_d = r_outst - CW'(1);
            default: w_outst_d = r_outst;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_granted <= '0;
            r_outst   <= '0;
        end else begin
            r_granted <= w_granted_d;
            r_outst   <= w_outst_d;
        end
    end

    for (genvar g = 0; g < MP; g++) begin : g_resp
        neureka_tcdm_resp_fifo #(
            .DEPTH (R_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_push  (tcdm_r_valid_i[g]),
            .i_data  (tcdm_r_data_i[32*g +: 32]),
            .i_pop   (w_pop),
            .o_data  (r_data_o[32*g +: 32]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && !gnt_o) |=> (req_i && $stable({add_i, wen_i, be_i, data_i})));

    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_outst <= CW'(R_DEPTH));

endmodule

// File: tb/tb_neureka_tcdm_splitter.sv
// Scoreboard bench: a per-port TCDM responder model plus an in-order wide read scoreboard.
module tb_neureka_tcdm_splitter;

    localparam int unsigned MP   = 9;
    localparam int unsigned BW   = MP * 32;
    localparam int unsigned RD   = 4;
    localparam int unsigned RING = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_i;
    logic             gnt_o;
    logic [31:0]      add_i;
    logic             wen_i;
    logic [BW/8-1:0]  be_i;
    logic [BW-1:0]    data_i;
    logic [BW-1:0]    r_data_o;
    logic             r_valid_o;
    logic             r_ready_i;
    logic [MP-1:0]    tcdm_req_o;
    logic [MP-1:0]    tcdm_gnt_i;
    logic [MP*32-1:0] tcdm_add_o;
    logic [MP-1:0]    tcdm_wen_o;
    logic [MP*4-1:0]  tcdm_be_o;
    logic [MP*32-1:0] tcdm_data_o;
    logic [MP*32-1:0] tcdm_r_data_i  = '0;
    logic [MP-1:0]    tcdm_r_valid_i = '0;

    always #5 clk_i = ~clk_i;

    neureka_tcdm_splitter #(
        .MP      (MP),
        .BW      (BW),
        .R_DEPTH (RD),
        .GATE_BE (1'b1)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .add_i          (add_i),
        .wen_i          (wen_i),
        .be_i           (be_i),
        .data_i         (data_i),
        .r_data_o       (r_data_o),
        .r_valid_o      (r_valid_o),
        .r_ready_i      (r_ready_i),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_data_o    (tcdm_data_o),
        .tcdm_r_data_i  (tcdm_r_data_i),
        .tcdm_r_valid_i (tcdm_r_valid_i)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    int unsigned   lat    [MP];
    int unsigned   hs_cnt [MP];
    logic [31:0]   rg_d   [MP][RING];
    int unsigned   rg_due [MP][RING];
    int unsigned   rg_wp  [MP];
    int unsigned   rg_rp  [MP];
    logic [BW-1:0] sb [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    function automatic logic [BW-1:0] exp_wide(input logic [31:0] a);
        logic [BW-1:0] v;
        for (int i = 0; i < MP; i++) v[32*i +: 32] = mem_word(a + 32'(4 * i));
        return v;
    endfunction

    function automatic logic [BW-1:0] exp_addr(input logic [31:0] a);
        logic [BW-1:0] v;
        for (int i = 0; i < MP; i++) v[32*i +: 32] = a + 32'(4 * i);
        return v;
    endfunction

    // Handshake capture, response scheduling and wide-read scoreboard.
    always @(negedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MP; i++) begin
                rg_wp[i] = 0;
                rg_rp[i] = 0;
            end
            sb.delete();
        end else begin
            for (int i = 0; i < MP; i++) begin
                if (tcdm_req_o[i] && tcdm_gnt_i[i]) begin
                    hs_cnt[i]++;
                    if (tcdm_wen_o[i]) begin
                        rg_d[i][rg_wp[i] % RING]   = mem_word(tcdm_add_o[32*i +: 32]);
                        rg_due[i][rg_wp[i] % RING] = cyc + lat[i];
                        rg_wp[i]++;
                    end
                end
            end
            if (gnt_o && wen_i) sb.push_back(exp_wide(add_i));
            if (r_valid_o) begin
                if (sb.size() == 0) check_eq("sb_unexpected", BW'(1), '0);
                else if (r_ready_i) check_eq("rdata", r_data_o, sb.pop_front());
                else check_eq("rhold", r_data_o, sb[0]);
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        for (int i = 0; i < MP; i++) begin
            if (!rst_i && rg_rp[i] != rg_wp[i] && rg_due[i][rg_rp[i] % RING] <= cyc) begin
                tcdm_r_valid_i[i]          = 1'b1;
                tcdm_r_data_i[32*i +: 32]  = rg_d[i][rg_rp[i] % RING];
                rg_rp[i]++;
            end else begin
                tcdm_r_valid_i[i]          = 1'b0;
                tcdm_r_data_i[32*i +: 32]  = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while ((sb.size() != 0 || r_valid_o) && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, BW'(sb.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        logic [MP-1:0] m;
        rst_i = 1'b1; req_i = 1'b0; wen_i = 1'b1; add_i = '0; be_i = '1; data_i = '0;
        r_ready_i = 1'b1; tcdm_gnt_i = '1;
        for (int i = 0; i < MP; i++) begin
            lat[i] = 1;
            hs_cnt[i] = 0;
        end
        repeat (3) tick();
        rst_i = 1'b0;
        mid();
        check_eq("rst_gnt", BW'(gnt_o), '0);
        check_eq("rst_rvalid", BW'(r_valid_o), '0);
        check_eq("rst_req", BW'(tcdm_req_o), '0);
        check_eq("rst_rdata", r_data_o, '0);

        // Read with all ports granting at once.
        tick(); req_i = 1'b1; wen_i = 1'b1; add_i = '0; be_i = '1;
        mid();
        check_eq("rd_gnt0", BW'(gnt_o), BW'(1));
        check_eq("rd_req_all", BW'(tcdm_req_o), BW'({MP{1'b1}}));
        check_eq("rd_addr", tcdm_add_o, exp_addr(32'h0));
        check_eq("rd_wen", BW'(tcdm_wen_o), BW'({MP{1'b1}}));
        tick(); req_i = 1'b0;
        wait_drain("rd_drain");

        // Staggered grants: port k grants in cycle k.
        for (int i = 0; i < MP; i++) hs_cnt[i] = 0;
        req_i = 1'b1; add_i = 32'h200;
        for (int k = 0; k < MP; k++) begin
            tcdm_gnt_i = MP'(1) << k;
            m = {MP{1'b1}} << k;
            mid();
            check_eq($sformatf("stag_req%0d", k), BW'(tcdm_req_o), BW'(m));
            check_eq($sformatf("stag_gnt%0d", k), BW'(gnt_o), BW'(k == MP - 1));
            tick();
        end
        req_i = 1'b0; tcdm_gnt_i = '1;
        for (int i = 0; i < MP; i++) check_eq($sformatf("stag_once%0d", i), BW'(hs_cnt[i]), BW'(1));
        wait_drain("stag_drain");

        // Write with only port 1 byte-enabled, grant delayed one cycle.
        req_i = 1'b1; wen_i = 1'b0; add_i = 32'h300; be_i = '0; be_i[7:4] = 4'hF;
        for (int i = 0; i < MP; i++) data_i[32*i +: 32] = 32'hD000_0000 + 32'(i);
        tcdm_gnt_i = '0;
        mid();
        check_eq("wr_req_p1", BW'(tcdm_req_o), BW'(2));
        check_eq("wr_gnt_wait", BW'(gnt_o), '0);
        check_eq("wr_be1", BW'(tcdm_be_o[7:4]), BW'(4'hF));
        check_eq("wr_data1", BW'(tcdm_data_o[63:32]), BW'(32'hD000_0001));
        check_eq("wr_wen", BW'(tcdm_wen_o), '0);
        tick(); tcdm_gnt_i = '1;
        mid();
        check_eq("wr_gnt", BW'(gnt_o), BW'(1));
        check_eq("wr_req_p1b", BW'(tcdm_req_o), BW'(2));
        tick(); be_i = '0;
        mid();
        check_eq("wr_be0_gnt", BW'(gnt_o), BW'(1));
        check_eq("wr_be0_req", BW'(tcdm_req_o), '0);
        tick(); req_i = 1'b0; wen_i = 1'b1; be_i = '1;

        // Credit limit: four reads fill the credits, the fifth waits for a pop.
        r_ready_i = 1'b0; req_i = 1'b1;
        for (int k = 0; k < RD; k++) begin
            add_i = 32'h400 + 32'(k * 64);
            mid();
            check_eq($sformatf("cr_gnt%0d", k), BW'(gnt_o), BW'(1));
            tick();
        end
        add_i = 32'h500;
        for (int k = 0; k < 4; k++) begin
            mid();
            check_eq($sformatf("cr_block_gnt%0d", k), BW'(gnt_o), '0);
            check_eq($sformatf("cr_block_req%0d", k), BW'(tcdm_req_o), '0);
            tick();
        end
        r_ready_i = 1'b1;
        mid();
        check_eq("cr_pop_cycle", BW'(gnt_o), '0);
        tick(); r_ready_i = 1'b0;
        mid();
        check_eq("cr_after_pop", BW'(gnt_o), BW'(1));
        tick(); req_i = 1'b0; r_ready_i = 1'b1;
        wait_drain("cr_drain");

        // Port 3 answers late; two back-to-back reads must not interleave.
        lat[3] = 3;
        req_i = 1'b1; add_i = 32'h40;
        mid(); check_eq("late_gnt0", BW'(gnt_o), BW'(1));
        tick(); add_i = 32'h80;
        mid(); check_eq("late_gnt1", BW'(gnt_o), BW'(1));
        tick(); req_i = 1'b0;
        mid(); check_eq("late_wait2", BW'(r_valid_o), '0);
        tick();
        mid(); check_eq("late_wait3", BW'(r_valid_o), '0);
        tick();
        wait_drain("late_drain");
        lat[3] = 1;

        // Reset with three reads outstanding and a partially granted fourth.
        r_ready_i = 1'b0; req_i = 1'b1; wen_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            add_i = 32'h600 + 32'(k * 64);
            mid();
            check_eq($sformatf("rs_gnt%0d", k), BW'(gnt_o), BW'(1));
            tick();
        end
        add_i = 32'h700; tcdm_gnt_i = MP'(3);
        mid(); check_eq("rs_partial", BW'(gnt_o), '0);
        tick(); tcdm_gnt_i = '0;
        m = ~MP'(3);
        mid(); check_eq("rs_req_rem", BW'(tcdm_req_o), BW'(m));
        tick(); rst_i = 1'b1; req_i = 1'b0;
        mid();
        check_eq("rs_gnt", BW'(gnt_o), '0);
        check_eq("rs_rvalid", BW'(r_valid_o), '0);
        check_eq("rs_req", BW'(tcdm_req_o), '0);
        check_eq("rs_rdata", r_data_o, '0);
        tick(); rst_i = 1'b0; tcdm_gnt_i = '1; req_i = 1'b1;
        for (int k = 0; k < RD; k++) begin
            add_i = 32'h800 + 32'(k * 64);
            mid();
            if (k == 0) check_eq("rs_fresh_req", BW'(tcdm_req_o), BW'({MP{1'b1}}));
            check_eq($sformatf("rs_fresh_gnt%0d", k), BW'(gnt_o), BW'(1));
            tick();
        end
        req_i = 1'b0; r_ready_i = 1'b1;
        wait_drain("rs_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
